// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 key-schedule constants, RCON lookup and scheduler states
package aes_pkg;

   localparam logic [3:0] AES_NR = 4'd10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      EMIT = 2'd2
   } state_t;

   // Valid for rounds 1..10; any other index yields zero.
   function automatic logic [7:0] rcon(input logic [3:0] r);
      case (r)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/aes_inv_key_sched_if.sv
// rtl/aes_inv_key_sched_if.sv - request/round-key handshake bundle of the inverse key scheduler
interface aes_inv_key_sched_if;
   logic         start;
   logic [127:0] key_in;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] rk;
   logic [3:0]   rk_round;
   logic         done;

   modport master (
      output start, key_in, rk_ready,
      input  busy, rk_valid, rk, rk_round, done
   );

   modport slave (
      input  start, key_in, rk_ready,
      output busy, rk_valid, rk, rk_round, done
   );
endinterface

// File: rtl/aes_inv_key_step.sv
// rtl/aes_inv_key_step.sv - combinational AES-128 key-expansion round undo (round r to r-1)
module aes_inv_key_step
   import aes_pkg::*;
(
   input  logic [127:0] key,
   input  logic [3:0]   round,
   output logic [127:0] key_out
);
   logic [31:0] w0, w1, w2, w3;
   logic [31:0] w0_n, w1_n, w2_n, w3_n;
   logic [31:0] rot_w, sub_w;

   assign {w0, w1, w2, w3} = key;

   assign w3_n = w3 ^ w2;
   assign w2_n = w2 ^ w1;
   assign w1_n = w1 ^ w0;

   assign rot_w = {w3_n[23:0], w3_n[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      s_box u_s_box (
         .a (rot_w[8*i +: 8]),
         .y (sub_w[8*i +: 8])
      );
   end

   assign w0_n    = w0 ^ sub_w ^ {rcon(round), 24'h0};
   assign key_out = {w0_n, w1_n, w2_n, w3_n};
endmodule

// File: rtl/s_box.sv
// rtl/s_box.sv - combinational AES forward S-box
module s_box (
   input  logic [7:0] a,
   output logic [7:0] y
);
   // Row 0x00 sits in the top bytes, so entry a lives at packed index ~a.
   localparam logic [255:0][7:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   assign y = SBOX_TABLE[~a];
endmodule

// File: rtl/aes_inv_key_sched.sv
// rtl/aes_inv_key_sched.sv - AES-128 round keys in decryption order, one per handshake
// AES_INV_FWD_EXPAND_EN: key_in is the cipher key, expanded forward to round 10 first.
module aes_inv_key_sched
   import aes_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   aes_inv_key_sched_if.slave  bus
);
   state_t       state_q, state_d;
   logic [127:0] key_q;
   logic [3:0]   round_q;
   logic         done_q;
   logic [127:0] inv_key;
   logic         accept, xfer, last_xfer;

   // A start landing in the done cycle is dropped: busy still covers it.
   assign accept    = (state_q == IDLE) && !done_q && bus.start;
   assign xfer      = (state_q == EMIT) && bus.rk_ready;
   assign last_xfer = xfer && (round_q == 4'd0);

   aes_inv_key_step u_inv_step (
      .key     (key_q),
      .round   (round_q),
      .key_out (inv_key)
   );

`ifdef AES_INV_FWD_EXPAND_EN
   logic [31:0]  fw_rot, fw_sub;
   logic [31:0]  fw0, fw1, fw2, fw3;
   logic [127:0] fwd_key;

   assign fw_rot = {key_q[23:0], key_q[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_fwd_sbox
      s_box u_s_box (
         .a (fw_rot[8*i +: 8]),
         .y (fw_sub[8*i +: 8])
      );
   end

   assign fw0     = key_q[127:96] ^ fw_sub ^ {rcon(round_q + 4'd1), 24'h0};
   assign fw1     = key_q[95:64] ^ fw0;
   assign fw2     = key_q[63:32] ^ fw1;
   assign fw3     = key_q[31:0]  ^ fw2;
   assign fwd_key = {fw0, fw1, fw2, fw3};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
`ifdef AES_INV_FWD_EXPAND_EN
               state_d = LOAD;
`else
               state_d = EMIT;
`endif
            end
         end
`ifdef AES_INV_FWD_EXPAND_EN
         LOAD: begin
            if (round_q == AES_NR - 4'd1) begin
               state_d = EMIT;
            end
         end
`endif
         EMIT: begin
            if (last_xfer) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy     = done_q || (state_q != IDLE);
      bus.done     = done_q;
      bus.rk_valid = 1'b0;
      bus.rk       = '0;
      bus.rk_round = '0;
      if (state_q == EMIT) begin
         bus.rk_valid = 1'b1;
         bus.rk       = key_q;
         bus.rk_round = round_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_q   <= '0;
         round_q <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= last_xfer;
         if (accept) begin
            key_q <= bus.key_in;
`ifdef AES_INV_FWD_EXPAND_EN
            round_q <= 4'd0;
`else
            round_q <= AES_NR;
`endif
         end
`ifdef AES_INV_FWD_EXPAND_EN
         else if (state_q == LOAD) begin
            key_q   <= fwd_key;
            round_q <= round_q + 4'd1;
         end
`endif
         else if (xfer && (round_q != 4'd0)) begin
            key_q   <= inv_key;
            round_q <= round_q - 4'd1;
         end
      end
   end
endmodule

// File: doc/aes_inv_key_sched.md
# aes_inv_key_sched

Sequential AES-128 inverse key scheduler for the decryption datapath. From a stored key it emits the round keys in decryption order, round 10 down to round 0, one per handshake. Each step undoes one forward key-expansion round. It sits between key load and the inverse-cipher round engine, so decryption needs no 176-byte key store.

## Interface
- No parameters. Round count 10 and the RCON table are fixed constants in the package.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request to capture `key_in`. Ignored while `busy`=1.
- `key_in` in 128: load key, word 0 in [127:96]. It is the round-10 key, or the round-0 cipher key when `AES_INV_FWD_EXPAND_EN` is defined.
- `busy` out 1: high from the cycle after an accepted `start` until the cycle after `done`.
- `rk_valid` out 1: `rk`/`rk_round` hold a valid key.
- `rk_ready` in 1: consumer accepts the key. A transfer happens when `rk_valid & rk_ready`.
- `rk` out 128: current round key.
- `rk_round` out 4: round index of `rk`, 10 down to 0.
- `done` out 1: one-cycle pulse, the cycle after the round-0 key transfers.

## Operation
- States:
  - IDLE to LOAD on `start`. LOAD is present only when the macro is defined.
  - LOAD to EMIT.
  - EMIT to IDLE.
- IDLE behaviour:
  - `start`=1 registers `key_in` into `key_q`.
  - Without the macro: set `round_q`=10, go to EMIT.
  - With the macro: set `round_q`=0, go to LOAD.
- LOAD: each cycle applies the forward step with RCON[`round_q`+1] and increments `round_q`. At `round_q`=10 it goes to EMIT.
- EMIT:
  - `rk_valid`=1, `rk`=`key_q`, `rk_round`=`round_q`.
  - On a transfer with `round_q`>0: `key_q` takes the inverse step, `round_q` decrements.
  - On a transfer with `round_q`=0: go to IDLE and pulse `done`.
- Inverse step from round r to r-1, with w0..w3 the words of `key_q`:
  - w3' = w3^w2
  - w2' = w2^w1
  - w1' = w1^w0
  - w0' = w0 ^ SubWord(RotWord(w3')) ^ {RCON[r], 24'h0}
  - RotWord is a left byte rotate.
- Results follow FIPS-197 key expansion.
- All XOR is 32-bit, with no carries. RCON[1..10] = 01,02,04,08,10,20,40,80,1b,36.

## Timing
- Reset values: `busy`=0, `rk_valid`=0, `rk`=0, `rk_round`=0, `done`=0. State is IDLE.
- Reset asserted mid-operation aborts the sequence immediately. No `done` is produced.
- `start` accepted at edge N:
  - Without the macro: `rk_valid`=1 from cycle N+1.
  - With the macro: `rk_valid`=1 from cycle N+11.
- Holding `rk_ready`=1 gives 11 keys in 11 consecutive cycles. `done` is in the cycle after the last key.
- While `rk_valid`=1 and `rk_ready`=0, `rk` and `rk_round` hold stable. `rk_valid` does not drop.
- `rk_valid`=0 in IDLE and LOAD.
- `start` together with `done`, or any time while `busy`=1, is ignored.
- `start` is accepted again in the cycle after `done`, once `busy` is low.

## Configuration
- `AES_INV_FWD_EXPAND_EN` defined:
  - `key_in` is the cipher key.
  - The LOAD state runs 10 forward steps before the first key is emitted. Latency is 11 cycles.
- Not defined:
  - `key_in` must be the round-10 key. LOAD and the forward logic are absent.
  - Latency is 1 cycle.

## Structure
- Package `aes_pkg`:
  - `AES_NR`=10
  - `RCON` function or table indexed 1..10
  - state enum {IDLE, LOAD, EMIT}
- Sub-module `aes_inv_key_step`:
  - Combinational inverse step; inputs key and round, output key.
  - Four existing `s_box` instances on RotWord(w3').
- Forward step, macro-enabled only: reuse the team's existing forward round-key module.
- One top instance of the step. It is shared with the forward path only if the timing budget requires it.

## Test plan
- Macro off, `key_in`=d014f9a8c9ee2589e13f0cc8b6630ca6, `rk_ready`=1:
  - rounds 10..0 over 11 consecutive cycles.
  - round 9 = ac7766f319fadc2128d12941575c006e.
  - round 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - `done` one cycle after round 0.
- Macro on, `key_in`=2b7e151628aed2a6abf7158809cf4f3c:
  - first `rk_valid` at N+11, `rk`=d014f9a8c9ee2589e13f0cc8b6630ca6, `rk_round`=10.
- Backpressure: random `rk_ready` with 50% duty.
  - `rk` stable while stalled.
  - Sequence and values identical to the first test.
- `start` pulsed during EMIT round 5: ignored, sequence continues to round 0 unchanged.
- `rst_n` low at round 4: all outputs 0 asynchronously. A new `start` after release restarts from round 10.
- `start` in the cycle of `done`: ignored. `start` one cycle later: accepted.
